// File: rtl/ramp_pkg.sv
// Shared defaults and derived sizes for the ramp scratch RAM.
package ramp_pkg;

  localparam int unsigned R_DEFAULT = 5;
  localparam int unsigned W_DEFAULT = 3;
  localparam int unsigned DEPTH     = 2 ** R_DEFAULT;
  localparam int unsigned DWIDTH    = 2 ** W_DEFAULT;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } access_e;

endpackage

// File: rtl/ramp_store.sv
// Memory array with a registered read port; everything clears on async reset.
module ramp_store
  import ramp_pkg::*;
#(
  parameter int unsigned R = R_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_rd,
  input  logic [R-1:0]      addr,
  input  logic [(2**W)-1:0] d_in,
  output logic [(2**W)-1:0] d_out
);

  localparam int unsigned DEP = 2 ** R;
  localparam int unsigned DW  = 2 ** W;

  logic [DW-1:0] mem [DEP];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEP; i++) begin
        mem[i] <= '0;
      end
      d_out <= '0;
    end else if (wr_rd == ACC_WRITE) begin
      mem[addr] <= d_in;
    end else begin
      d_out <= mem[addr];
    end
  end

endmodule

// File: rtl/ramp_ram.sv
// Single-port RAM with per-location written tracking and empty/full flags.
module ramp_ram
  import ramp_pkg::*;
#(
  parameter int unsigned R = R_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_rd,
  input  logic [R-1:0]      addr,
  input  logic [(2**W)-1:0] d_in,
  output logic [(2**W)-1:0] d_out,
  output logic              empty,
  output logic              full
);

  localparam int unsigned DEP      = 2 ** R;
  localparam logic [R:0]  FULL_CNT = (R + 1)'(DEP);

  logic [DEP-1:0] valid;
  logic [R:0]     count;

  ramp_store #(
    .R (R),
    .W (W)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .wr_rd (wr_rd),
    .addr  (addr),
    .d_in  (d_in),
    .d_out (d_out)
  );

  // Each location contributes to count at most once, so count cannot pass DEP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      count <= '0;
    end else if (wr_rd == ACC_WRITE && !valid[addr]) begin
      valid[addr] <= 1'b1;
      if (count != FULL_CNT) begin
        count <= count + 1'b1;
      end
    end
  end

  always_comb begin
    empty = (count == '0);
    full  = (count == FULL_CNT);
  end

endmodule

// File: tb/tb_ramp_ram.sv
// Directed self-checking bench for ramp_ram with default R=5, W=3.
module tb_ramp_ram;

  logic       clk;
  logic       rst;
  logic       wr_rd;
  logic [4:0] addr;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       empty;
  logic       full;

  int unsigned n_tests;
  int unsigned n_fail;

  ramp_ram #(
    .R (5),
    .W (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_rd (wr_rd),
    .addr  (addr),
    .d_in  (d_in),
    .d_out (d_out),
    .empty (empty),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fill_val(input int unsigned a);
    return 8'((a * 7 + 3) % 256);
  endfunction

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_rd = 1'b1;
    addr  = a;
    d_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    wr_rd = 1'b0;
    addr  = a;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #20;
    rst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    wr_rd   = 1'b0;
    addr    = '0;
    d_in    = '0;

    // Reset
    #21;
    check("rst_dout", d_out, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    rst = 1'b1;
    rd(5'd0);
    check("rst_rd0", d_out, 0);
    rd(5'd31);
    check("rst_rd31", d_out, 0);

    // Fill
    for (int unsigned a = 0; a < 32; a++) begin
      wr(5'(a), fill_val(a));
      check("fill_empty", empty, 0);
      check($sformatf("fill_full_%0d", a), full, (a == 31) ? 1 : 0);
    end
    check("fill_dout_hold", d_out, 0);

    // Readback
    for (int unsigned a = 0; a < 32; a++) begin
      rd(5'(a));
      check($sformatf("rb_%0d", a), d_out, fill_val(a));
      check("rb_full", full, 1);
      check("rb_empty", empty, 0);
    end

    // Overwrite
    pulse_reset();
    wr(5'd5, 8'h11);
    wr(5'd5, 8'h22);
    wr(5'd5, 8'h33);
    check("ow_empty", empty, 0);
    check("ow_full", full, 0);
    rd(5'd5);
    check("ow_rd5", d_out, 8'h33);

    // Mixed
    wr(5'd2, 8'hAA);
    check("mx_dout_hold", d_out, 8'h33);
    rd(5'd2);
    check("mx_rd2", d_out, 8'hAA);
    rd(5'd9);
    check("mx_rd9", d_out, 0);
    check("mx_empty", empty, 0);

    // Reset mid-fill
    pulse_reset();
    for (int unsigned a = 0; a < 16; a++) begin
      wr(5'(a), fill_val(a));
    end
    rd(5'd3);
    check("mf_rd3", d_out, fill_val(3));
    check("mf_empty", empty, 0);
    wr_rd = 1'b1;
    addr  = 5'd16;
    d_in  = fill_val(16);
    #1;
    rst = 1'b0;
    #1;
    check("mf_async_dout", d_out, 0);
    check("mf_async_empty", empty, 1);
    check("mf_async_full", full, 0);
    #20;
    rst = 1'b1;
    for (int unsigned a = 0; a < 17; a++) begin
      rd(5'(a));
      check($sformatf("mf_rd_%0d", a), d_out, 0);
    end
    check("mf_end_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
